// File: rtl/nanci_pkg.sv
// Shared definitions for NANCI node controllers.
//   addr_width() : node-address width derived from the node count N
//   wr_bit()     : bit position of the write flag in a packet
//   addr_lsb()   : lowest bit of the address field in a packet
//   CNT_W        : width of the compute-latency counter
//   state_e      : application sequencer states
package nanci_pkg;

  localparam int CNT_W = 14;

  function automatic int addr_width(input int n);
    case (n)
      1024:    return 10;
      256:     return 8;
      64:      return 6;
      16:      return 4;
      default: return 2;
    endcase
  endfunction

  // Packet layout: {write flag, address, data}
  function automatic int wr_bit(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_ISSUE,
    S_CAPTURE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/nanci_cycle_counter.sv
// Loadable 14-bit down-counter used to time an application's compute phase.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (has priority over en_i)
//   load_val_i    : value to load
//   en_i          : decrement by one; holds at zero
//   le1_o         : counter currently reads 0 or 1
module nanci_cycle_counter
  import nanci_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             le1_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign le1_o = (count_q <= CNT_W'(1));

endmodule

// File: rtl/nanci_app_sequencer.sv
// Per-node sequencer driving one application instance against the NANCI
// network port: times the compute phase, strobes runnable, captures the
// request packet, issues it with valid/ready and, for reads, forwards the
// matching result back. Repeats ROUNDS times per start, then reports done.
//   clk, rst                      : clock, asynchronous active-low reset
//   start                         : begin a run (honoured in IDLE/DONE only)
//   compute_cycles                : application compute latency
//   runnable                      : one-cycle strobe to the application
//   app_request / app_result      : packets from / to the application
//   net_req, net_req_valid/ready  : request channel to the network
//   net_result, net_result_valid  : read responses from the network
//   busy, done, round_count       : run status
//   stray_result                  : sticky, a result arrived outside WAIT
module nanci_app_sequencer
  import nanci_pkg::*;
#(
  parameter  int N          = 1024,
  parameter  int I          = 0,
  parameter  int DATA_WIDTH = 32,
  parameter  int ROUNDS     = 4,
  localparam int ADDR_WIDTH = addr_width(N),
  localparam int WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] compute_cycles,
  output logic             runnable,
  input  logic [WIDTH:0]   app_request,
  output logic [WIDTH:0]   app_result,
  output logic [WIDTH:0]   net_req,
  output logic             net_req_valid,
  input  logic             net_req_ready,
  input  logic [WIDTH:0]   net_result,
  input  logic             net_result_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      round_count,
  output logic             stray_result
);

  localparam int          WR_BIT   = wr_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [15:0] ROUNDS_L = 16'(ROUNDS);
  localparam bit          INDEX_OK = (I >= 0) && (I < N);

  state_e         state_q;
  logic           runnable_q;
  logic [WIDTH:0] app_result_q;
  logic [WIDTH:0] net_req_q;
  logic           net_req_valid_q;
  logic           busy_q;
  logic           done_q;
  logic [15:0]    round_cnt_q;
  logic [15:0]    round_cnt_d;
  logic           stray_q;

  logic start_run;
  logic send_fire;
  logic result_fire;
  logic round_end;
  logic last_round;
  logic cnt_load;
  logic cnt_en;
  logic cnt_le1;

  always_comb begin
    start_run   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    send_fire   = (state_q == S_SEND) && net_req_ready;
    result_fire = (state_q == S_WAIT) && net_result_valid;
    // A write completes its round at the handshake, a read at its result.
    round_end   = (send_fire && net_req_q[WR_BIT]) || result_fire;
    round_cnt_d = round_cnt_q + 16'd1;
    last_round  = (round_cnt_d == ROUNDS_L);
    // The counter is loaded on every edge that enters COMPUTE so it reads
    // compute_cycles during the first COMPUTE cycle.
    cnt_load    = start_run || (round_end && !last_round);
    cnt_en      = (state_q == S_COMPUTE);
  end

  nanci_cycle_counter u_cycle_counter (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (cnt_load),
    .load_val_i (compute_cycles),
    .en_i       (cnt_en),
    .le1_o      (cnt_le1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      runnable_q      <= 1'b0;
      app_result_q    <= '0;
      net_req_q       <= '0;
      net_req_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      round_cnt_q     <= '0;
      stray_q         <= 1'b0;
    end else begin
      runnable_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_COMPUTE;
            round_cnt_q <= '0;
            stray_q     <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        S_COMPUTE: begin
          if (cnt_le1) begin
            state_q    <= S_ISSUE;
            runnable_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // The application registered its request at the ISSUE edge.
          net_req_q       <= app_request;
          net_req_valid_q <= 1'b1;
          state_q         <= S_SEND;
        end
        S_SEND: begin
          if (net_req_ready) begin
            net_req_valid_q <= 1'b0;
            if (!net_req_q[WR_BIT]) begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (net_result_valid) begin
            app_result_q <= net_result;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      if (round_end) begin
        round_cnt_q <= round_cnt_d;
        if (last_round) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= S_COMPUTE;
        end
      end

      // Placed last so a result landing in the same cycle as start still
      // registers as stray.
      if (net_result_valid && (state_q != S_WAIT)) begin
        stray_q <= 1'b1;
      end
    end
  end

  assign runnable      = runnable_q;
  assign app_result    = app_result_q;
  assign net_req       = net_req_q;
  assign net_req_valid = net_req_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign round_count   = round_cnt_q;
  assign stray_result  = stray_q;

  a_index_ok : assert property (@(posedge clk) disable iff (!rst) INDEX_OK);

  // A pending request must stay valid and unchanged until accepted.
  a_req_stable : assert property (@(posedge clk) disable iff (!rst)
    (net_req_valid && !net_req_ready) |=> (net_req_valid && $stable(net_req)));

endmodule

// File: tb/tb_nanci_app_sequencer.sv
module tb_nanci_app_sequencer;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int W  = AW + DW;
  localparam int R  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [13:0]   compute_cycles = '0;
  logic          runnable;
  logic [W:0]    app_request = '0;
  logic [W:0]    app_result;
  logic [W:0]    net_req;
  logic          net_req_valid;
  logic          net_req_ready = 1'b0;
  logic [W:0]    net_result = '0;
  logic          net_result_valid = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   round_count;
  logic          stray_result;

  always #5 clk = ~clk;

  nanci_app_sequencer #(
    .N          (N),
    .I          (3),
    .DATA_WIDTH (DW),
    .ROUNDS     (R)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .compute_cycles   (compute_cycles),
    .runnable         (runnable),
    .app_request      (app_request),
    .app_result       (app_result),
    .net_req          (net_req),
    .net_req_valid    (net_req_valid),
    .net_req_ready    (net_req_ready),
    .net_result       (net_result),
    .net_result_valid (net_result_valid),
    .busy             (busy),
    .done             (done),
    .round_count      (round_count),
    .stray_result     (stray_result)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cur_k = 0;
  logic [W:0] exp_app = '0;

  // Per-round scenario description consumed by run_and_check.
  int          c_a [R];
  bit          wr_a[R];
  int          d_a [R];
  int          l_a [R];
  logic [31:0] rd_a[R];
  int          stray_edge;
  logic [W:0]  pkt_a[R];
  logic [W:0]  res_a[R];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cur_k, obs, exp);
    end
  endtask

  function automatic logic [W:0] rnd_pkt();
    return {1'($urandom), AW'($urandom), DW'($urandom)};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".runnable"},  64'(runnable), 64'd0);
    chk({tag, ".net_req"},   64'(net_req), 64'd0);
    chk({tag, ".valid"},     64'(net_req_valid), 64'd0);
    chk({tag, ".app_res"},   64'(app_result), 64'd0);
    chk({tag, ".busy"},      64'(busy), 64'd0);
    chk({tag, ".done"},      64'(done), 64'd0);
    chk({tag, ".rcount"},    64'(round_count), 64'd0);
    chk({tag, ".stray"},     64'(stray_result), 64'd0);
  endtask

  // Timeline model: edge 0 is the edge that samples start. A round starting
  // at edge s with compute value C strobes runnable after edge s+max(C,1),
  // presents the request from s+max(C,1)+2, is accepted at the edge that sees
  // ready (d ready-low cycles later), and ends there (write) or L edges later
  // when the result is sampled (read). The next round starts at that edge.
  task automatic run_and_check(input string tag);
    int s [R+1];
    int ce[R];
    int hs[R];
    int en[R];
    int done_e;
    int cp;
    int nk;
    int e_rc;
    logic e_run;
    logic e_val;
    logic [W:0] e_pkt;

    s[0] = 0;
    for (int r = 0; r < R; r++) begin
      cp       = (c_a[r] == 0) ? 1 : c_a[r];
      ce[r]    = s[r] + cp;
      hs[r]    = s[r] + cp + 3 + d_a[r];
      en[r]    = wr_a[r] ? hs[r] : hs[r] + l_a[r];
      s[r+1]   = en[r];
      pkt_a[r] = {wr_a[r], AW'($urandom), DW'($urandom)};
      res_a[r] = {1'($urandom), AW'($urandom), rd_a[r]};
    end
    done_e = en[R-1];

    start            = 1'b1;
    compute_cycles   = 14'(c_a[0]);
    net_req_ready    = 1'($urandom);
    net_result_valid = 1'b0;
    net_result       = rnd_pkt();
    app_request      = rnd_pkt();

    for (int k = 0; k <= done_e + 2; k++) begin
      @(posedge clk);
      #1;
      cur_k = k;
      e_run = 1'b0;
      e_val = 1'b0;
      e_pkt = '0;
      e_rc  = 0;
      for (int r = 0; r < R; r++) begin
        if (k == ce[r]) e_run = 1'b1;
        if ((k >= ce[r] + 2) && (k < hs[r])) begin
          e_val = 1'b1;
          e_pkt = pkt_a[r];
        end
        if (en[r] <= k) e_rc++;
        if (!wr_a[r] && (k == en[r])) exp_app = res_a[r];
      end
      chk({tag, ".runnable"}, 64'(runnable), 64'(e_run));
      chk({tag, ".valid"},    64'(net_req_valid), 64'(e_val));
      if (e_val) chk({tag, ".net_req"}, 64'(net_req), 64'(e_pkt));
      chk({tag, ".rcount"},   64'(round_count), 64'(e_rc));
      chk({tag, ".busy"},     64'(busy), 64'(k < done_e));
      chk({tag, ".done"},     64'(done), 64'(k >= done_e));
      chk({tag, ".stray"},    64'(stray_result), 64'((stray_edge >= 0) && (k >= stray_edge)));
      chk({tag, ".app_res"},  64'(app_result), 64'(exp_app));

      // Inputs for the next edge; anything the sequencer should ignore is
      // randomized so mistimed sampling shows up.
      nk             = k + 1;
      start          = (nk <= done_e) ? 1'($urandom) : 1'b0;
      compute_cycles = 14'($urandom);
      net_req_ready  = 1'($urandom);
      net_result_valid = (nk == stray_edge);
      net_result     = rnd_pkt();
      app_request    = rnd_pkt();
      for (int r = 0; r < R; r++) begin
        if (nk == s[r]) compute_cycles = 14'(c_a[r]);
        if ((nk >= ce[r] + 3) && (nk < hs[r])) net_req_ready = 1'b0;
        if (nk == hs[r]) net_req_ready = 1'b1;
        if (!wr_a[r] && (nk == en[r])) begin
          net_result_valid = 1'b1;
          net_result       = res_a[r];
        end
        if (nk == ce[r] + 2) app_request = pkt_a[r];
      end
    end
  endtask

  task automatic set_round(input int r, input int c, input bit wr, input int d,
                           input int l, input logic [31:0] rd);
    c_a[r]  = c;
    wr_a[r] = wr;
    d_a[r]  = d;
    l_a[r]  = l;
    rd_a[r] = rd;
  endtask

  initial begin
    bit found;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    exp_app = '0;

    // Two write rounds, C=5, immediate acceptance: 8 cycles per round
    stray_edge = -1;
    set_round(0, 5, 1'b1, 0, 1, 32'h0);
    set_round(1, 5, 1'b1, 0, 1, 32'h0);
    run_and_check("wr_c5");

    // Zero and one cycle compute phases
    set_round(0, 0, 1'b1, 0, 1, 32'h0);
    set_round(1, 1, 1'b1, 0, 1, 32'h0);
    run_and_check("c0_c1");

    // Ready withheld for 7 cycles
    set_round(0, 3, 1'b1, 7, 1, 32'h0);
    set_round(1, 2, 1'b1, 0, 1, 32'h0);
    run_and_check("ready_low7");

    // Read with 10-cycle network latency, then a write round
    set_round(0, 4, 1'b0, 0, 10, 32'hA5A5_A5A5);
    set_round(1, 2, 1'b1, 1, 1, 32'h0);
    run_and_check("read_a5");

    // Stray result during COMPUTE; the following run clears it
    stray_edge = 2;
    set_round(0, 6, 1'b1, 0, 1, 32'h0);
    set_round(1, 3, 1'b0, 2, 3, 32'h1234_5678);
    run_and_check("stray");
    stray_edge = -1;
    set_round(0, 2, 1'b1, 0, 1, 32'h0);
    set_round(1, 2, 1'b1, 0, 1, 32'h0);
    run_and_check("stray_clr");

    // Randomized runs
    for (int j = 0; j < 6; j++) begin
      for (int r = 0; r < R; r++) begin
        set_round(r, int'($urandom_range(0, 12)), 1'($urandom),
                  int'($urandom_range(0, 4)), int'($urandom_range(1, 6)), $urandom);
      end
      run_and_check("random");
    end

    // Reset asserted while a request is pending in SEND
    start            = 1'b1;
    compute_cycles   = 14'd2;
    net_req_ready    = 1'b0;
    net_result_valid = 1'b0;
    app_request      = {1'b1, AW'($urandom), DW'($urandom)};
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if (net_req_valid) found = 1'b1;
    end
    chk("rst_mid.reach_send", 64'(found), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid.still_valid", 64'(net_req_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid.async");
    exp_app = '0;
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid.held");
    rst = 1'b1;

    // Clean full sequence after reset
    set_round(0, 3, 1'b0, 1, 4, $urandom);
    set_round(1, 1, 1'b1, 2, 1, 32'h0);
    run_and_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
